// File: rtl/mdu_pkg.sv
// ============================================================================
// mdu_pkg : shared types and constants for the multiply/divide sequencer
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mdu_pkg;

    localparam int MDU_WIDTH = 32;
    localparam int MDU_CNT_W = $clog2(MDU_WIDTH);

    typedef enum logic [1:0] {
        MDU_MUL   = 2'b00,
        MDU_MULHU = 2'b01,
        MDU_DIVU  = 2'b10,
        MDU_REMU  = 2'b11
    } mdu_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } mdu_state_t;

endpackage

`default_nettype wire

// File: rtl/mdu_step.sv
// ============================================================================
// mdu_step : one combinational iteration on the {hi,lo} working register,
//            either shift-add multiply or restoring trial-subtract divide.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shl_rem;
    logic [WIDTH:0] trial;

    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        shl_rem = {hi, lo[WIDTH-1]};
        // The top bit of the (WIDTH+1)-bit difference is the borrow.
        trial   = shl_rem - {1'b0, opnd};
        if (is_div) begin
            if (trial[WIDTH]) begin
                hi_next = shl_rem[WIDTH-1:0];
                lo_next = {lo[WIDTH-2:0], 1'b0};
            end else begin
                hi_next = trial[WIDTH-1:0];
                lo_next = {lo[WIDTH-2:0], 1'b1};
            end
        end else begin
            hi_next = sum[WIDTH:1];
            lo_next = {sum[0], lo[WIDTH-1:1]};
        end
    end

endmodule

`default_nettype wire

// File: rtl/mdu_sequencer.sv
// ============================================================================
// mdu_sequencer : multi-cycle unsigned MUL/MULHU/DIVU/REMU controller with
//                 busy stall output, done pulse and flush abort.
//                 Optional macro MDU_EARLY_OUT_EN: multiplies finish as soon
//                 as no multiplier bits remain.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             flush,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    mdu_state_t       state;
    mdu_op_t          op_q;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] opnd;

    logic [WIDTH-1:0] hi_n;
    logic [WIDTH-1:0] lo_n;
    logic [WIDTH-1:0] fin_hi;
    logic [WIDTH-1:0] fin_lo;
    logic             is_div;
    logic             exit_now;

    assign is_div = op_q[1];

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (is_div),
        .hi      (hi),
        .lo      (lo),
        .opnd    (opnd),
        .hi_next (hi_n),
        .lo_next (lo_n)
    );

`ifdef MDU_EARLY_OUT_EN
    localparam logic [CNT_W:0] LAST = (CNT_W+1)'(WIDTH-1);

    logic [WIDTH-1:0]   mask;
    logic [2*WIDTH-1:0] shifted;

    // lo[count:0] still holds unprocessed multiplier bits; after this step
    // only lo[count:1] remain, and once those are zero the rest is pure shift.
    assign mask     = {WIDTH{1'b1}} >> (LAST - {1'b0, count});
    assign exit_now = (count == '0) || (!is_div && (((lo & mask) >> 1) == '0));
    assign shifted  = {hi_n, lo_n} >> count;
    assign fin_hi   = shifted[2*WIDTH-1:WIDTH];
    assign fin_lo   = shifted[WIDTH-1:0];
`else
    assign exit_now = (count == '0);
    assign fin_hi   = hi_n;
    assign fin_lo   = lo_n;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            op_q   <= MDU_MUL;
            count  <= '0;
            hi     <= '0;
            lo     <= '0;
            opnd   <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !flush) begin
                        op_q  <= mdu_op_t'(op);
                        count <= CNT_W'(WIDTH-1);
                        hi    <= '0;
                        // Multiply keeps the multiplier in lo; divide keeps the dividend there.
                        lo    <= op[1] ? a : b;
                        opnd  <= op[1] ? b : a;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (flush) begin
                        count <= '0;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        hi <= hi_n;
                        lo <= lo_n;
                        if (exit_now) begin
                            count  <= '0;
                            done   <= 1'b1;
                            result <= op_q[0] ? fin_hi : fin_lo;
                            state  <= S_DONE;
                        end else begin
                            count <= count - 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mdu_sequencer.sv
// ============================================================================
// tb_mdu_sequencer : self-checking bench for mdu_sequencer (arithmetic model
//                    plus per-cycle busy/done/result comparison).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mdu_sequencer;
    import mdu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model state: one outstanding operation and the currently visible result.
    bit           m_valid = 1'b0;
    int           m_start = 0;
    int           m_end   = 0;
    int           m_abort = -1;
    logic [W-1:0] m_pend  = '0;
    logic [W-1:0] m_res   = '0;
    int           m_lat   = -1;

    mdu_sequencer #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .flush   (flush),
        .op      (op),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] ref_result(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        case (o)
            2'd0:    return p[W-1:0];
            2'd1:    return p[2*W-1:W];
            2'd2:    return (y == '0) ? {W{1'b1}} : x / y;
            default: return (y == '0) ? x : x % y;
        endcase
    endfunction

    // Cycles from the start cycle to the done cycle.
    function automatic int ref_latency(input logic [1:0] o, input logic [W-1:0] y);
`ifdef MDU_EARLY_OUT_EN
        if (!o[1]) begin
            int n;
            n = 1;
            for (int i = 0; i < W; i++) if (y[i]) n = i + 1;
            return n + 1;
        end
`endif
        return W + 1;
    endfunction

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : cmp
        logic eb;
        logic ed;
        int   lim;
        lim = (m_abort >= 0) ? m_abort : m_end;
        eb  = m_valid && (cyc > m_start) && (cyc <= lim);
        ed  = m_valid && (m_abort < 0) && (cyc == m_end);
        if (ed) m_res = m_pend;
        chk("busy", {{(W-1){1'b0}}, busy}, {{(W-1){1'b0}}, eb});
        chk("done", {{(W-1){1'b0}}, done}, {{(W-1){1'b0}}, ed});
        chk("result", result, m_res);
        if (done === 1'b1) m_lat = cyc - m_start;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        op      = o;
        a       = x;
        b       = y;
        start   = 1'b1;
        m_valid = 1'b1;
        m_start = cyc;
        m_end   = cyc + ref_latency(o, y);
        m_abort = -1;
        m_pend  = ref_result(o, x, y);
        m_lat   = -1;
        tick();
        start = 1'b0;
        op    = 2'($urandom_range(0, 3));
        a     = $urandom;
        b     = $urandom;
    endtask

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        issue(o, x, y);
        while (cyc <= m_end) tick();
    endtask

    initial begin
        logic [1:0]   ro;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           t0;

        #1 reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        chk("reset_busy", {{(W-1){1'b0}}, busy}, '0);
        chk("reset_result", result, '0);

        run_op(MDU_MUL, 32'd7, 32'd6);
        chk("mul_7x6", result, 32'd42);
`ifdef MDU_EARLY_OUT_EN
        chk("mul_7x6_lat", m_lat, 32'd4);
`else
        chk("mul_7x6_lat", m_lat, 32'd33);
`endif
        run_op(MDU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("mulhu_max", result, 32'hFFFF_FFFE);
        run_op(MDU_DIVU, 32'd100, 32'd7);
        chk("divu_100_7", result, 32'd14);
        chk("divu_lat", m_lat, 32'd33);
        run_op(MDU_REMU, 32'd100, 32'd7);
        chk("remu_100_7", result, 32'd2);
        run_op(MDU_DIVU, 32'd5, 32'd0);
        chk("divu_by0", result, 32'hFFFF_FFFF);
        run_op(MDU_REMU, 32'd5, 32'd0);
        chk("remu_by0", result, 32'd5);

        // Flush in the tenth RUN cycle; no done must follow and result holds.
        issue(MDU_MUL, 32'd123, 32'h8000_0456);
        while (cyc < m_start + 10) tick();
        flush   = 1'b1;
        m_abort = cyc;
        tick();
        flush = 1'b0;
        chk("flush_busy", {{(W-1){1'b0}}, busy}, '0);
        t0 = cyc;
        while (cyc < t0 + 40) tick();
        chk("flush_result", result, 32'd5);

        // start and flush together in IDLE: nothing is accepted.
        op    = MDU_MUL;
        a     = 32'd1;
        b     = 32'd1;
        start = 1'b1;
        flush = 1'b1;
        tick();
        start = 1'b0;
        flush = 1'b0;
        repeat (3) tick();
        chk("start_flush_busy", {{(W-1){1'b0}}, busy}, '0);
        chk("start_flush_result", result, 32'd5);

        // start while busy is ignored, then back-to-back at done+1.
        issue(MDU_MUL, 32'd3, 32'd4);
        tick();
        op    = MDU_DIVU;
        a     = 32'd99;
        b     = 32'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (cyc <= m_end) tick();
        chk("mul_3x4", result, 32'd12);
        run_op(MDU_DIVU, 32'd9, 32'd2);
        chk("divu_9_2", result, 32'd4);

        run_op(MDU_MUL, 32'd9, 32'd1);
        chk("mul_9x1", result, 32'd9);
`ifdef MDU_EARLY_OUT_EN
        chk("mul_9x1_lat", m_lat, 32'd2);
`else
        chk("mul_9x1_lat", m_lat, 32'd33);
`endif

        // Asynchronous reset in the middle of an operation.
        issue(MDU_MULHU, 32'hDEAD_BEEF, 32'h8765_4321);
        repeat (5) tick();
        #2 reset_n = 1'b0;
        m_valid = 1'b0;
        m_res   = '0;
        #1;
        chk("async_busy", {{(W-1){1'b0}}, busy}, '0);
        chk("async_done", {{(W-1){1'b0}}, done}, '0);
        chk("async_result", result, '0);
        tick();
        reset_n = 1'b1;
        t0 = cyc;
        while (cyc < t0 + 40) tick();
        chk("async_no_done_result", result, '0);

        for (int i = 0; i < 10; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i % 3 == 0) ? 32'($urandom_range(0, 300)) : $urandom;
            run_op(ro, ra, rb);
            chk("random_result", result, ref_result(ro, ra, rb));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
